// File: rtl/mem_access_pkg.sv
//==============================================================================
// Module      : mem_access_pkg
// Description : Shared op encodings, FSM state type and default memory depth
//               for the load/store sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_access_pkg;

    // Depth of the data memory in 32-bit words
    localparam int DEFAULT_DEPTH_WORDS = 2048;

    // Memory operation encodings
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Word ops need a 4-byte aligned address, halfword ops a 2-byte one
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:          bad = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH:  bad = lo[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_merge.sv
//==============================================================================
// Module      : byte_lane_merge
// Description : Little-endian lane extraction with sign/zero extension for
//               loads, and sub-word lane replacement for stores.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte/halfword and extend it; build the merged store word
    always_comb begin
        w_byte   = word_in[{addr_lo, 3'b000} +: 8];
        w_half   = addr_lo[1] ? word_in[31:16] : word_in[15:0];
        load_val = word_in;
        merged   = word_in;
        case (op)
            OP_LH:   load_val = {{16{w_half[15]}}, w_half};
            OP_LHU:  load_val = {16'h0000, w_half};
            OP_LB:   load_val = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  load_val = {24'h000000, w_byte};
            OP_SB:   merged[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            OP_SH:   merged[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            default: load_val = word_in;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//==============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store sequencer driving a word-
//               addressed data memory; sub-word stores use read-modify-write,
//               bad addresses complete with err and no memory access.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata_out,
    output logic        CS,
    output logic        DM_R,
    output logic        DM_W,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [31:0] C_DEPTH = 32'(DEPTH_WORDS);

    state_t      state_q,  state_d;
    logic [2:0]  op_q,     op_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] merge_q,  merge_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic        w_bad_req;
    logic [31:0] w_word_in;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    // Misalignment or word index beyond the memory depth rejects the request
    assign w_bad_req = is_misaligned(op, addr[1:0]) || ({2'b00, addr[31:2]} >= C_DEPTH);

    // Loads extract from live memory data; the RMW write merges into the captured word
    assign w_word_in = (state_q == ST_RMW_WR) ? merge_q : dm_rdata;

    byte_lane_merge u_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .word_in    (w_word_in),
        .store_data (wdata_q),
        .load_val   (w_load_val),
        .merged     (w_merged)
    );

    // Next-state and request/result latch logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = w_bad_req;
                    if (w_bad_req) begin
                        state_d = ST_DONE;
                    end else begin
                        case (op)
                            OP_SW:        state_d = ST_STORE;
                            OP_SH, OP_SB: state_d = ST_RMW_RD;
                            default:      state_d = ST_LOAD;
                        endcase
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = w_load_val;
                state_d = ST_DONE;
            end
            ST_STORE:  state_d = ST_DONE;
            ST_RMW_RD: begin
                merge_d = dm_rdata;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and latch registers; reset aborts any operation and clears results
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
        err  = (state_q == ST_DONE) && err_q;
    end

    // Memory strobes; gating with reset keeps a reset cycle from writing memory
    always_comb begin
        DM_R = ~reset && ((state_q == ST_LOAD)  || (state_q == ST_RMW_RD));
        DM_W = ~reset && ((state_q == ST_STORE) || (state_q == ST_RMW_WR));
        CS   = DM_R || DM_W;
    end

    // Memory address/data, held steady by the latches for the whole access cycle
    always_comb begin
        dm_addr  = {addr_q[31:2], 2'b00};
        dm_wdata = 32'h0;
        if (state_q == ST_STORE) begin
            dm_wdata = wdata_q;
        end else if (state_q == ST_RMW_WR) begin
            dm_wdata = w_merged;
        end
    end

    assign rdata_out = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//==============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with a behavioural
//               data memory, vector table and scoreboard queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, CS, DM_R, DM_W;
    logic [31:0] rdata_out, dm_addr, dm_wdata, dm_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:2047];
    int cs_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          chk_idx;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [0:17];
    vec_t sb_q [$];

    mem_access_unit #(.DEPTH_WORDS(2048)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata_out(rdata_out),
        .CS(CS), .DM_R(DM_R), .DM_W(DM_W), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on rising edge
    assign dm_rdata = (CS && DM_R) ? mem[dm_addr[12:2]] : 32'h0;
    always @(posedge clk) begin
        if (CS && DM_W) mem[dm_addr[12:2]] <= dm_wdata;
    end

    // Strobe activity counters sampled mid-cycle
    always @(negedge clk) begin
        if (CS)   cs_cnt   <= cs_cnt + 1;
        if (DM_R) rd_cnt   <= rd_cnt + 1;
        if (DM_W) wr_cnt   <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                                input logic e, input logic [31:0] r, input int idx,
                                input logic [31:0] w);
        vec_t v;
        v.op = o; v.addr = a; v.wdata = d; v.exp_err = e; v.exp_rdata = r;
        v.chk_idx = idx; v.exp_word = w;
        if (e) begin
            v.exp_lat = 0; v.exp_rd = 0; v.exp_wr = 0;
        end else if (o == OP_SW) begin
            v.exp_lat = 1; v.exp_rd = 0; v.exp_wr = 1;
        end else if (o == OP_SH || o == OP_SB) begin
            v.exp_lat = 2; v.exp_rd = 1; v.exp_wr = 1;
        end else begin
            v.exp_lat = 1; v.exp_rd = 1; v.exp_wr = 0;
        end
        return v;
    endfunction

    // Issue one request, wait for done with a bound, and check it against the scoreboard
    task automatic run_op(input vec_t v, input int k);
        int n;
        int cs0, rd0, wr0;
        vec_t e;
        sb_q.push_back(v);
        req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        req = 1'b0;
        cs0 = cs_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
        chk($sformatf("v%0d_busy", k), {31'b0, busy}, 32'h1);
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL v%0d_timeout actual=no_done required=done", k);
            void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL v%0d_sb_empty actual=done required=no_done", k);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d_lat", k),   32'(n), 32'(e.exp_lat));
            chk($sformatf("v%0d_err", k),   {31'b0, err}, {31'b0, e.exp_err});
            chk($sformatf("v%0d_rdata", k), rdata_out, e.exp_rdata);
            chk($sformatf("v%0d_cs", k),    32'(cs_cnt - cs0), 32'(e.exp_rd + e.exp_wr));
            chk($sformatf("v%0d_rd", k),    32'(rd_cnt - rd0), 32'(e.exp_rd));
            chk($sformatf("v%0d_wr", k),    32'(wr_cnt - wr0), 32'(e.exp_wr));
            chk($sformatf("v%0d_mem", k),   mem[e.chk_idx], e.exp_word);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle", k), {30'b0, busy, done}, 32'h0);
    endtask

    initial begin
        int d0;
        vecs[0]  = mk(OP_SW,  32'h10,   32'h8899AABB, 1'b0, 32'h00000000, 4, 32'h8899AABB);
        vecs[1]  = mk(OP_LB,  32'h13,   32'h0,        1'b0, 32'hFFFFFF88, 4, 32'h8899AABB);
        vecs[2]  = mk(OP_LBU, 32'h12,   32'h0,        1'b0, 32'h00000099, 4, 32'h8899AABB);
        vecs[3]  = mk(OP_LH,  32'h10,   32'h0,        1'b0, 32'hFFFFAABB, 4, 32'h8899AABB);
        vecs[4]  = mk(OP_LHU, 32'h12,   32'h0,        1'b0, 32'h00008899, 4, 32'h8899AABB);
        vecs[5]  = mk(OP_LW,  32'h10,   32'h0,        1'b0, 32'h8899AABB, 4, 32'h8899AABB);
        vecs[6]  = mk(OP_SW,  32'h20,   32'h11223344, 1'b0, 32'h8899AABB, 8, 32'h11223344);
        vecs[7]  = mk(OP_SB,  32'h21,   32'h000000EE, 1'b0, 32'h8899AABB, 8, 32'h1122EE44);
        vecs[8]  = mk(OP_SH,  32'h22,   32'h0000CAFE, 1'b0, 32'h8899AABB, 8, 32'hCAFEEE44);
        vecs[9]  = mk(OP_LW,  32'h02,   32'h0,        1'b1, 32'h8899AABB, 4, 32'h8899AABB);
        vecs[10] = mk(OP_SH,  32'h05,   32'h0000BEEF, 1'b1, 32'h8899AABB, 4, 32'h8899AABB);
        vecs[11] = mk(OP_SW,  32'h2000, 32'hDEADBEEF, 1'b1, 32'h8899AABB, 8, 32'hCAFEEE44);
        vecs[12] = mk(OP_LB,  32'h11,   32'h0,        1'b0, 32'hFFFFFFAA, 4, 32'h8899AABB);
        vecs[13] = mk(OP_LBU, 32'h10,   32'h0,        1'b0, 32'h000000BB, 4, 32'h8899AABB);
        vecs[14] = mk(OP_SW,  32'h00,   32'h00000001, 1'b0, 32'h000000BB, 0, 32'h00000001);
        vecs[15] = mk(OP_LW,  32'h00,   32'h0,        1'b0, 32'h00000001, 0, 32'h00000001);
        vecs[16] = mk(OP_SB,  32'h23,   32'h0000007F, 1'b0, 32'h00000001, 8, 32'h7FFEEE44);
        vecs[17] = mk(OP_LH,  32'h22,   32'h0,        1'b0, 32'h00007FFE, 8, 32'h7FFEEE44);

        reset = 1'b1; req = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", {29'b0, busy, done, err}, 32'h0);
        chk("rst_strobes", {29'b0, CS, DM_R, DM_W}, 32'h0);
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) run_op(vecs[i], i);

        // Request pulsed while busy must be dropped
        req = 1'b1; op = OP_LW; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        op = OP_SW; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        req = 1'b0;
        chk("ign_done", {31'b0, done}, 32'h1);
        chk("ign_rdata", rdata_out, 32'h8899AABB);
        @(posedge clk); #1;
        chk("ign_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("ign_busy_later", {31'b0, busy}, 32'h0);
        chk("ign_mem", mem[4], 32'h8899AABB);

        // Reset during the RMW write cycle suppresses the write and the done pulse
        req = 1'b1; op = OP_SB; addr = 32'h20; wdata = 32'h00000055;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rmwrst_wr_cycle", {29'b0, CS, DM_R, DM_W}, 32'h5);
        reset = 1'b1;
        #1;
        chk("rmwrst_gated", {29'b0, CS, DM_R, DM_W}, 32'h0);
        d0 = done_cnt;
        @(posedge clk); #1;
        chk("rmwrst_status", {29'b0, busy, done, err}, 32'h0);
        chk("rmwrst_strobes", {29'b0, CS, DM_R, DM_W}, 32'h0);
        chk("rmwrst_rdata", rdata_out, 32'h0);
        chk("rmwrst_dm_addr", dm_addr, 32'h0);
        chk("rmwrst_dm_wdata", dm_wdata, 32'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rmwrst_no_done", 32'(done_cnt - d0), 32'h0);
        chk("rmwrst_mem", mem[8], 32'h7FFEEE44);
        chk("rmwrst_idle", {31'b0, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
